// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: ID-stage operands, pipeline control and forwarding/stall results
// exchanged between the pipeline (master) and the forwarding scoreboard (slave).
interface fwd_scoreboard_if #(
    parameter int AW = 4,
    parameter int FW = 2,
    parameter int CNT_W = 16
) ();
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic [AW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_is_load;
    logic          flush;
    logic          hold;
    logic [FW-1:0] fwd_a;
    logic [FW-1:0] fwd_b;
    logic          stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_regwrite, id_is_load,
        output flush, hold,
        input  fwd_a, fwd_b, stall, stall_cnt
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_regwrite, id_is_load,
        input  flush, hold,
        output fwd_a, fwd_b, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: EX operand forward selects and ID load-use stall, driven by a private
// shift register of in-flight destination tags (slot 0 = EX .. slot DEPTH = WB).
module fwd_scoreboard #(
    parameter int AW = 4,
    parameter int DEPTH = 3,
    parameter int LOAD_STAGE = 2,
    parameter int ZERO_REG = 1,
    parameter int CNT_W = 16,
    localparam int FW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst_n,
    fwd_scoreboard_if.slave sb
);
    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          rw;
        logic          ld;
    } slot_t;

    slot_t            slot [0:DEPTH];
    logic [AW-1:0]    ex_rs, ex_rt;
    logic             ex_rs_u, ex_rt_u;
    logic [CNT_W-1:0] cnt;
    logic [FW-1:0]    fa, fb;
    logic             haz_rs, haz_rt, stall;

    function automatic logic writes(slot_t s, logic [AW-1:0] r);
        return s.v && s.rw && (s.rd == r) && !(ZERO_REG != 0 && r == '0);
    endfunction

    // Scanning oldest-to-youngest and overwriting lets the youngest writer win.
    always_comb begin
        fa = '0;
        fb = '0;
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (slot[0].v && ex_rs_u && writes(slot[k], ex_rs)) fa = FW'(k);
            if (slot[0].v && ex_rt_u && writes(slot[k], ex_rt)) fb = FW'(k);
        end
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (writes(slot[j], sb.id_rs)) haz_rs = slot[j].ld && (j + 1 < LOAD_STAGE);
            if (writes(slot[j], sb.id_rt)) haz_rt = slot[j].ld && (j + 1 < LOAD_STAGE);
        end
        stall = sb.id_valid && ((sb.id_rs_used && haz_rs) || (sb.id_rt_used && haz_rt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DEPTH; k++) slot[k] <= '0;
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_rs_u <= 1'b0;
            ex_rt_u <= 1'b0;
            cnt     <= '0;
        end else if (!sb.hold) begin
            for (int k = 1; k <= DEPTH; k++) slot[k] <= slot[k-1];
            slot[0] <= (sb.flush || stall) ? '0
                     : slot_t'({sb.id_valid, sb.id_rd, sb.id_regwrite, sb.id_is_load});
            ex_rs   <= sb.id_rs;
            ex_rt   <= sb.id_rt;
            ex_rs_u <= sb.id_rs_used;
            ex_rt_u <= sb.id_rt_used;
            if (stall && cnt != '1) cnt <= cnt + 1'b1;
        end
    end

    assign sb.fwd_a     = fa;
    assign sb.fwd_b     = fb;
    assign sb.stall     = stall;
    assign sb.stall_cnt = cnt;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: three scoreboard configurations driven by shared ID stimulus and
// checked against an instruction-history reference model.
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, ru, tu, rw, ld, flush, hold;
    logic [3:0] rs, rt, rd;

    fwd_scoreboard_if #(.AW(4), .FW(2), .CNT_W(16)) b0 ();
    fwd_scoreboard_if #(.AW(4), .FW(3), .CNT_W(16)) b1 ();
    fwd_scoreboard_if #(.AW(4), .FW(2), .CNT_W(2))  b2 ();

    fwd_scoreboard #(.AW(4), .DEPTH(3), .LOAD_STAGE(2), .ZERO_REG(1), .CNT_W(16))
        u0 (.clk(clk), .rst_n(rst_n), .sb(b0));
    fwd_scoreboard #(.AW(4), .DEPTH(4), .LOAD_STAGE(3), .ZERO_REG(1), .CNT_W(16))
        u1 (.clk(clk), .rst_n(rst_n), .sb(b1));
    fwd_scoreboard #(.AW(4), .DEPTH(3), .LOAD_STAGE(2), .ZERO_REG(1), .CNT_W(2))
        u2 (.clk(clk), .rst_n(rst_n), .sb(b2));

    assign b0.id_valid = id_valid, b0.id_rs = rs, b0.id_rt = rt, b0.id_rs_used = ru,
           b0.id_rt_used = tu, b0.id_rd = rd, b0.id_regwrite = rw, b0.id_is_load = ld,
           b0.flush = flush, b0.hold = hold;
    assign b1.id_valid = id_valid, b1.id_rs = rs, b1.id_rt = rt, b1.id_rs_used = ru,
           b1.id_rt_used = tu, b1.id_rd = rd, b1.id_regwrite = rw, b1.id_is_load = ld,
           b1.flush = flush, b1.hold = hold;
    assign b2.id_valid = id_valid, b2.id_rs = rs, b2.id_rt = rt, b2.id_rs_used = ru,
           b2.id_rt_used = tu, b2.id_rd = rd, b2.id_regwrite = rw, b2.id_is_load = ld,
           b2.flush = flush, b2.hold = hold;

    logic [31:0] a_fa [3], a_fb [3], a_st [3], a_cnt [3];
    assign a_fa[0] = 32'(b0.fwd_a), a_fb[0] = 32'(b0.fwd_b), a_st[0] = 32'(b0.stall), a_cnt[0] = 32'(b0.stall_cnt);
    assign a_fa[1] = 32'(b1.fwd_a), a_fb[1] = 32'(b1.fwd_b), a_st[1] = 32'(b1.stall), a_cnt[1] = 32'(b1.stall_cnt);
    assign a_fa[2] = 32'(b2.fwd_a), a_fb[2] = 32'(b2.fwd_b), a_st[2] = 32'(b2.stall), a_cnt[2] = 32'(b2.stall_cnt);

    // Reference model: the instructions that entered EX, newest at index 0.
    typedef struct {
        bit v, rw, ld, ru, tu;
        int rd, rs, rt;
    } ins_t;

    ins_t p [3][5];
    int   cnt [3];
    int   dep [3]  = '{3, 4, 3};
    int   lst [3]  = '{2, 3, 2};
    int   cmax [3] = '{65535, 65535, 3};
    int   vectors = 0;
    int   fails = 0;

    function automatic bit wr(ins_t i, int r);
        return i.v && i.rw && i.rd == r && r != 0;
    endfunction

    function automatic int exp_fwd(int d, bit b);
        int r = b ? p[d][0].rt : p[d][0].rs;
        bit u = b ? p[d][0].tu : p[d][0].ru;
        if (!p[d][0].v || !u) return 0;
        for (int k = 1; k <= dep[d]; k++) if (wr(p[d][k], r)) return k;
        return 0;
    endfunction

    function automatic bit load_use(int d, int r);
        for (int j = 0; j < dep[d]; j++) if (wr(p[d][j], r)) return p[d][j].ld && (j + 1 < lst[d]);
        return 0;
    endfunction

    function automatic bit exp_stall(int d);
        return id_valid && ((ru && load_use(d, int'(rs))) || (tu && load_use(d, int'(rt))));
    endfunction

    function automatic void mdl_reset();
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0;
            for (int k = 0; k < 5; k++) p[d][k] = '{default: 0};
        end
    endfunction

    function automatic void mdl_clock();
        bit st;
        for (int d = 0; d < 3; d++) begin
            st = exp_stall(d);
            if (!hold) begin
                for (int k = dep[d]; k >= 1; k--) p[d][k] = p[d][k-1];
                if (flush || st) p[d][0] = '{default: 0};
                else p[d][0] = '{v: id_valid, rw: rw, ld: ld, ru: ru, tu: tu,
                                 rd: int'(rd), rs: int'(rs), rt: int'(rt)};
                if (st && cnt[d] < cmax[d]) cnt[d]++;
            end
        end
    endfunction

    task automatic chk(string tag, logic [31:0] act, int exp);
        vectors++;
        assert (act === 32'(exp)) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("u%0d fwd_a @%0t", d, $time), a_fa[d], exp_fwd(d, 1'b0));
            chk($sformatf("u%0d fwd_b @%0t", d, $time), a_fb[d], exp_fwd(d, 1'b1));
            chk($sformatf("u%0d stall @%0t", d, $time), a_st[d], int'(exp_stall(d)));
            chk($sformatf("u%0d stall_cnt @%0t", d, $time), a_cnt[d], cnt[d]);
        end
    endtask

    task automatic put_id(bit v, int s, int t, bit su, bit tu_, int d, bit w, bit l);
        id_valid = v; rs = 4'(s); rt = 4'(t); ru = su; tu = tu_; rd = 4'(d); rw = w; ld = l;
    endtask

    // Called right after a falling edge with ID inputs already driven.
    task automatic step(bit h, bit f);
        hold = h;
        flush = f;
        #2 check_all();
        @(posedge clk);
        if (rst_n) mdl_clock();
        @(negedge clk);
    endtask

    initial begin
        put_id(0, 0, 0, 0, 0, 0, 0, 0);
        hold = 0;
        flush = 0;
        mdl_reset();
        #2 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back ALU dependency
        put_id(1, 1, 2, 1, 1, 3, 1, 0); step(0, 0);
        put_id(1, 3, 1, 1, 1, 4, 1, 0); step(0, 0);
        put_id(1, 5, 3, 1, 1, 6, 1, 0); step(0, 0);
        put_id(0, 0, 0, 0, 0, 0, 0, 0); step(0, 0); step(0, 0);

        // youngest writer wins, r0 never forwarded
        put_id(1, 1, 1, 1, 1, 5, 1, 0); step(0, 0);
        put_id(1, 0, 0, 0, 0, 0, 1, 0); step(0, 0);
        put_id(1, 1, 1, 1, 1, 5, 1, 0); step(0, 0);
        put_id(1, 0, 5, 1, 1, 7, 1, 0); step(0, 0); step(0, 0);

        // load-use
        put_id(1, 1, 1, 1, 1, 2, 1, 1); step(0, 0);
        put_id(1, 2, 4, 1, 1, 8, 1, 0); step(0, 0); step(0, 0); step(0, 0);
        put_id(0, 0, 0, 0, 0, 0, 0, 0); step(0, 0); step(0, 0);

        // shadowing: younger ALU write hides the load
        put_id(1, 1, 1, 1, 1, 2, 1, 1); step(0, 0);
        put_id(1, 1, 1, 1, 1, 2, 1, 0); step(0, 0);
        put_id(1, 9, 2, 1, 1, 3, 1, 0); step(0, 0); step(0, 0);

        // hold during a load-use stall
        put_id(1, 1, 1, 1, 1, 7, 1, 1); step(0, 0);
        put_id(1, 7, 7, 1, 1, 8, 1, 0); step(1, 0); step(1, 0); step(1, 0);
        step(0, 0); step(0, 0);

        // flush drops the instruction entering EX
        put_id(1, 1, 1, 1, 1, 9, 1, 0); step(0, 1);
        put_id(1, 9, 9, 1, 1, 10, 1, 0); step(0, 0); step(0, 0);

        // asynchronous reset in the middle of a stall
        put_id(1, 1, 1, 1, 1, 6, 1, 1); step(0, 0);
        put_id(1, 6, 6, 1, 1, 0, 0, 0);
        #2 check_all();
        rst_n = 1'b0;
        #1 mdl_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // stall counter saturation on the narrow counter
        for (int i = 0; i < 5; i++) begin
            put_id(1, 1, 1, 1, 1, 1, 1, 1); step(0, 0);
            put_id(1, 1, 1, 1, 1, 0, 0, 0); step(0, 0); step(0, 0);
        end

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            put_id($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
